adder_arbiter: RTL and testbench

Shares one 8-bit combinational adder (operands A, B, carry-in Cin; sum S) between two requesters. Performs round-robin arbitration and sequences each operation: it drives the adder operands, waits a programmable settle time, captures the sum and returns it with a one-cycle acknowledge. It also encodes subtraction as A + ~B + 1, so clients can request add or subtract.

---
 rtl/adder_arbiter.sv | 121 ++++++++++++
 tb/tb_adder_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external combinational adder between two clients.
// Each operation: grant, hold operands SETTLE cycles, capture sum, one-cycle ack.
module adder_arbiter #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic             op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] res0,
    output logic [WIDTH-1:0] res1,
    output logic             busy,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t           state, state_nx;
    logic             gid, gid_nx;
    logic             last_grant, last_grant_nx;
    logic [3:0]       cnt, cnt_nx;
    logic [WIDTH-1:0] add_a_nx, add_b_nx, res0_nx, res1_nx;
    logic             add_cin_nx, ack0_nx, ack1_nx;
    logic             sel, sel_op;
    logic [WIDTH-1:0] sel_b;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_nx      = state;
        gid_nx        = gid;
        last_grant_nx = last_grant;
        cnt_nx        = cnt;
        add_a_nx      = add_a;
        add_b_nx      = add_b;
        add_cin_nx    = add_cin;
        res0_nx       = res0;
        res1_nx       = res1;
        ack0_nx       = 1'b0;
        ack1_nx       = 1'b0;
        sel           = (req0 && req1) ? ~last_grant : req1;
        sel_op        = sel ? op1 : op0;
        sel_b         = sel ? b1 : b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    gid_nx        = sel;
                    last_grant_nx = sel;
                    add_a_nx      = sel ? a1 : a0;
                    // Subtraction is a + ~b + 1 through the same adder.
                    add_b_nx      = sel_op ? ~sel_b : sel_b;
                    add_cin_nx    = sel_op;
                    cnt_nx        = CNT_LOAD;
                    state_nx      = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    if (gid) begin
                        res1_nx = add_s;
                        ack1_nx = 1'b1;
                    end else begin
                        res0_nx = add_s;
                        ack0_nx = 1'b1;
                    end
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gid        <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            add_a      <= '0;
            add_b      <= '0;
            add_cin    <= 1'b0;
            res0       <= '0;
            res1       <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_nx;
            gid        <= gid_nx;
            last_grant <= last_grant_nx;
            cnt        <= cnt_nx;
            add_a      <= add_a_nx;
            add_b      <= add_b_nx;
            add_cin    <= add_cin_nx;
            res0       <= res0_nx;
            res1       <= res1_nx;
            ack0       <= ack0_nx;
            ack1       <= ack1_nx;
            busy       <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: two instances (SETTLE=1 and SETTLE=3),
// vector table, hand-written corner sequences and a randomized transaction-level model.
module tb_adder_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0[2], op0[2], req1[2], op1[2];
    logic [7:0] a0[2], b0[2], a1[2], b1[2];
    logic       ack0[2], ack1[2], busy[2], add_cin[2];
    logic [7:0] res0[2], res1[2], add_a[2], add_b[2], add_s[2];

    int checks = 0;
    int errors = 0;
    int st[2] = '{1, 3};

    always #5 clk = ~clk;

    // Shared adders as seen by each instance.
    assign add_s[0] = add_a[0] + add_b[0] + {7'd0, add_cin[0]};
    assign add_s[1] = add_a[1] + add_b[1] + {7'd0, add_cin[1]};

    adder_arbiter #(.WIDTH(8), .SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0[0]), .op0(op0[0]), .a0(a0[0]), .b0(b0[0]),
        .req1(req1[0]), .op1(op1[0]), .a1(a1[0]), .b1(b1[0]),
        .ack0(ack0[0]), .ack1(ack1[0]), .res0(res0[0]), .res1(res1[0]),
        .busy(busy[0]), .add_a(add_a[0]), .add_b(add_b[0]),
        .add_cin(add_cin[0]), .add_s(add_s[0])
    );

    adder_arbiter #(.WIDTH(8), .SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0[1]), .op0(op0[1]), .a0(a0[1]), .b0(b0[1]),
        .req1(req1[1]), .op1(op1[1]), .a1(a1[1]), .b1(b1[1]),
        .ack0(ack0[1]), .ack1(ack1[1]), .res0(res0[1]), .res1(res1[1]),
        .busy(busy[1]), .add_a(add_a[1]), .add_b(add_b[1]),
        .add_cin(add_cin[1]), .add_s(add_s[1])
    );

    typedef struct {
        int         inst;
        int         cl;
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic get_ack(input int i, input int c);
        return (c == 1) ? ack1[i] : ack0[i];
    endfunction

    function automatic logic [7:0] get_res(input int i, input int c);
        return (c == 1) ? res1[i] : res0[i];
    endfunction

    task automatic set_cli(input int i, input int c, input logic r, input logic op,
                           input logic [7:0] a, input logic [7:0] b);
        if (c == 1) begin
            req1[i] = r; op1[i] = op; a1[i] = a; b1[i] = b;
        end else begin
            req0[i] = r; op0[i] = op; a0[i] = a; b0[i] = b;
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            set_cli(i, 0, 1'b0, 1'b0, 8'd0, 8'd0);
            set_cli(i, 1, 1'b0, 1'b0, 8'd0, 8'd0);
        end
    endtask

    task automatic check_zero(input int i, input string tag);
        check({tag, " ack0"}, 32'(ack0[i]), 0);
        check({tag, " ack1"}, 32'(ack1[i]), 0);
        check({tag, " res0"}, 32'(res0[i]), 0);
        check({tag, " res1"}, 32'(res1[i]), 0);
        check({tag, " busy"}, 32'(busy[i]), 0);
        check({tag, " add_a"}, 32'(add_a[i]), 0);
        check({tag, " add_b"}, 32'(add_b[i]), 0);
        check({tag, " add_cin"}, 32'(add_cin[i]), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One isolated request on instance i; ack expected SETTLE edges after the grant edge.
    task automatic single_op(input vec_t v);
        int         i = v.inst;
        int         c = v.cl;
        int         o = 1 - v.cl;
        logic [7:0] other_res, exp_b;
        exp_b = v.op ? ~v.b : v.b;
        @(posedge clk); #1;
        other_res = get_res(i, o);
        set_cli(i, c, 1'b1, v.op, v.a, v.b);
        @(posedge clk); #1;
        check("grant busy", 32'(busy[i]), 1);
        check("grant add_a", 32'(add_a[i]), 32'(v.a));
        check("grant add_b", 32'(add_b[i]), 32'(exp_b));
        check("grant add_cin", 32'(add_cin[i]), 32'(v.op));
        for (int k = 1; k <= st[i]; k++) begin
            @(posedge clk); #1;
            check("other ack", 32'(get_ack(i, o)), 0);
            check("other res", 32'(get_res(i, o)), 32'(other_res));
            if (k < st[i]) begin
                check("early ack", 32'(get_ack(i, c)), 0);
                check("held add_a", 32'(add_a[i]), 32'(v.a));
                check("held add_b", 32'(add_b[i]), 32'(exp_b));
            end else begin
                check("ack", 32'(get_ack(i, c)), 1);
                check("res", 32'(get_res(i, c)), 32'(v.exp));
                check("busy done", 32'(busy[i]), 1);
            end
        end
        set_cli(i, c, 1'b0, v.op, v.a, v.b);
        @(posedge clk); #1;
        check("ack fall", 32'(get_ack(i, c)), 0);
        check("idle busy", 32'(busy[i]), 0);
        check("res held", 32'(get_res(i, c)), 32'(v.exp));
    endtask

    // Transaction-level reference: grant at edge g, result at g+SETTLE, free after g+SETTLE+1.
    task automatic rand_run(input int i, input int n);
        logic       in_flight = 1'b0;
        int         g_edge = 0, g_cl = 0, last = 1;
        logic [7:0] pend = 8'd0, er0 = 8'd0, er1 = 8'd0, av, bv;
        logic       e0, e1, ov;
        for (int cyc = 0; cyc < n; cyc++) begin
            @(posedge clk);
            e0 = 1'b0; e1 = 1'b0;
            if (!in_flight) begin
                if (req0[i] || req1[i]) begin
                    if (req0[i] && req1[i]) g_cl = 1 - last;
                    else                    g_cl = req1[i] ? 1 : 0;
                    last = g_cl;
                    av = g_cl ? a1[i] : a0[i];
                    bv = g_cl ? b1[i] : b0[i];
                    ov = g_cl ? op1[i] : op0[i];
                    pend = ov ? av - bv : av + bv;
                    g_edge = cyc;
                    in_flight = 1'b1;
                end
            end else if (cyc == g_edge + st[i]) begin
                if (g_cl == 1) begin er1 = pend; e1 = 1'b1; end
                else           begin er0 = pend; e0 = 1'b1; end
            end else if (cyc == g_edge + st[i] + 1) begin
                in_flight = 1'b0;
            end
            #1;
            check("rnd ack0", 32'(ack0[i]), 32'(e0));
            check("rnd ack1", 32'(ack1[i]), 32'(e1));
            check("rnd res0", 32'(res0[i]), 32'(er0));
            check("rnd res1", 32'(res1[i]), 32'(er1));
            check("rnd busy", 32'(busy[i]), 32'(in_flight));
            for (int c = 0; c < 2; c++) begin
                logic r, acked;
                r = (c == 1) ? req1[i] : req0[i];
                acked = (c == 1) ? e1 : e0;
                if (acked)  r = ($urandom_range(1) == 1);
                else if (!r) r = ($urandom_range(2) == 0);
                set_cli(i, c, r, 1'($urandom_range(1)), 8'($urandom), 8'($urandom));
            end
        end
    endtask

    initial begin
        vec_t vt[$];
        int   ack_cl[$];
        int   ack_cyc[$];
        rst_n = 1'b0;
        clear_inputs();

        // Reset values, observed while rst_n is still low.
        #3;
        check_zero(0, "reset s1");
        check_zero(1, "reset s3");
        @(posedge clk); #1 rst_n = 1'b1;

        // Isolated operations, including wrap and subtract boundaries.
        vt.push_back('{0, 0, 1'b0, 8'd200, 8'd100, 8'd44});
        vt.push_back('{0, 1, 1'b1, 8'd5,   8'd9,   8'd252});
        vt.push_back('{0, 1, 1'b0, 8'd255, 8'd1,   8'd0});
        vt.push_back('{0, 0, 1'b1, 8'd0,   8'd1,   8'd255});
        vt.push_back('{1, 0, 1'b0, 8'd3,   8'd4,   8'd7});
        vt.push_back('{1, 1, 1'b1, 8'd100, 8'd100, 8'd0});
        vt.push_back('{1, 1, 1'b1, 8'd128, 8'd1,   8'd127});
        foreach (vt[k]) single_op(vt[k]);

        // Tie after reset: client 0 first, then strict alternation.
        do_reset();
        set_cli(0, 0, 1'b1, 1'b0, 8'd1, 8'd1);
        set_cli(0, 1, 1'b1, 1'b1, 8'd10, 8'd3);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            if (ack0[0] || ack1[0]) begin
                check("tie no overlap", 32'(ack0[0] && ack1[0]), 0);
                ack_cl.push_back(ack1[0] ? 1 : 0);
                ack_cyc.push_back(cyc);
            end
        end
        clear_inputs();
        check("tie ack count", 32'(ack_cl.size()), 4);
        foreach (ack_cl[k]) begin
            check("tie order", 32'(ack_cl[k]), 32'(k % 2));
            check("tie spacing", 32'(ack_cyc[k]), 32'(2 + 3 * k));
        end
        check("tie res0", 32'(res0[0]), 2);
        check("tie res1", 32'(res1[0]), 7);
        repeat (2) @(posedge clk);

        // Operands and request changed right after the grant edge.
        #1 set_cli(0, 0, 1'b1, 1'b0, 8'd7, 8'd8);
        @(posedge clk); #1;
        set_cli(0, 0, 1'b0, 1'b0, 8'd99, 8'd8);
        @(posedge clk); #1;
        check("stab ack0", 32'(ack0[0]), 1);
        check("stab res0", 32'(res0[0]), 15);
        begin
            int extra = 0;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                if (ack0[0]) extra++;
            end
            check("stab single ack", 32'(extra), 0);
        end

        // Reset during the second EXEC cycle of the SETTLE=3 instance.
        set_cli(1, 0, 1'b1, 1'b0, 8'd3, 8'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-reset busy", 32'(busy[1]), 1);
        rst_n = 1'b0;
        #1 check_zero(1, "mid reset");
        repeat (2) @(posedge clk);
        #1;
        check("reset ack0", 32'(ack0[1]), 0);
        set_cli(1, 0, 1'b1, 1'b0, 8'd20, 8'd5);
        set_cli(1, 1, 1'b1, 1'b0, 8'd50, 8'd6);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset grant", 32'(add_a[1]), 20);
        repeat (3) @(posedge clk);
        #1;
        check("post-reset ack0", 32'(ack0[1]), 1);
        check("post-reset res0", 32'(res0[1]), 25);
        clear_inputs();

        // Randomized traffic on each instance against the reference model.
        do_reset();
        rand_run(0, 400);
        do_reset();
        rand_run(1, 400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
